// File: rtl/bsg_mem_2r1w_sync_core.sv
// Generic 2-read / 1-write register file with registered (synchronous) reads.
// Each read port behaves as a 1R1W RAM sharing the single write port.
module bsg_mem_2r1w_sync_core #(
    parameter int width_p                = 1,
    parameter int els_p                  = 1,
    parameter int read_write_same_addr_p = 0,
    parameter int addr_width_lp          = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,

    input  logic                     r0_v_i,
    input  logic [addr_width_lp-1:0] r0_addr_i,
    output logic [width_p-1:0]       r0_data_o,

    input  logic                     r1_v_i,
    input  logic [addr_width_lp-1:0] r1_addr_i,
    output logic [width_p-1:0]       r1_data_o
);

    localparam logic [addr_width_lp:0] ELS_LP = (addr_width_lp + 1)'(els_p);

    logic [width_p-1:0] r_mem [els_p];
    logic [width_p-1:0] r_r0_data;
    logic [width_p-1:0] r_r1_data;

    logic               w_wr_in_range;
    logic               w_r0_in_range;
    logic               w_r1_in_range;
    logic               w_r0_hit;
    logic               w_r1_hit;
    logic [width_p-1:0] w_r0_next;
    logic [width_p-1:0] w_r1_next;

    // Out-of-range reads return zero; a same-address write is forwarded only
    // when write-through is enabled, otherwise the old word is returned.
    function automatic logic [width_p-1:0] read_mux(
        input logic               in_range,
        input logic               hit,
        input logic [width_p-1:0] wdata,
        input logic [width_p-1:0] stored
    );
        if (!in_range)
            return '0;
        if ((read_write_same_addr_p != 0) && hit)
            return wdata;
        return stored;
    endfunction

    assign w_wr_in_range = ({1'b0, w_addr_i}  < ELS_LP);
    assign w_r0_in_range = ({1'b0, r0_addr_i} < ELS_LP);
    assign w_r1_in_range = ({1'b0, r1_addr_i} < ELS_LP);

    assign w_r0_hit = w_v_i && r0_v_i && (r0_addr_i == w_addr_i);
    assign w_r1_hit = w_v_i && r1_v_i && (r1_addr_i == w_addr_i);

    assign w_r0_next = read_mux(w_r0_in_range, w_r0_hit, w_data_i, r_mem[r0_addr_i]);
    assign w_r1_next = read_mux(w_r1_in_range, w_r1_hit, w_data_i, r_mem[r1_addr_i]);

    // Storage is never reset; writes are simply blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && w_v_i && w_wr_in_range)
            r_mem[w_addr_i] <= w_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_r0_data <= '0;
            r_r1_data <= '0;
        end else begin
            if (r0_v_i)
                r_r0_data <= w_r0_next;
            if (r1_v_i)
                r_r1_data <= w_r1_next;
        end
    end

    assign r0_data_o = r_r0_data;
    assign r1_data_o = r_r1_data;

    // Simulation-only reporting of illegal accesses.
    always @(posedge clk_i) begin
        if (reset_n_i && w_v_i && !w_wr_in_range)
            $warning("bsg_mem_2r1w_sync_core: illegal write to address %0d (els_p=%0d)",
                     w_addr_i, els_p);
        if (reset_n_i && (read_write_same_addr_p == 0) && w_r0_hit)
            $warning("bsg_mem_2r1w_sync_core: illegal r0/w collision at address %0d", w_addr_i);
        if (reset_n_i && (read_write_same_addr_p == 0) && w_r1_hit)
            $warning("bsg_mem_2r1w_sync_core: illegal r1/w collision at address %0d", w_addr_i);
    end

endmodule

// File: tb/tb_bsg_mem_2r1w_sync_core.sv
// Scoreboard bench: three instances (write-through 32x32, read-before-write 32x32,
// read-before-write 20x32) share stimulus and are compared against an array model.
module tb_bsg_mem_2r1w_sync_core;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        w_v, w_v20;
    logic [4:0]  w_addr, r0_addr, r1_addr;
    logic [31:0] w_data;
    logic        r0_v, r1_v;
    logic [31:0] o [6];

    bsg_mem_2r1w_sync_core #(.width_p(32), .els_p(32), .read_write_same_addr_p(1)) u_wt (
        .clk_i(clk), .reset_n_i(rst_n),
        .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
        .r0_v_i(r0_v), .r0_addr_i(r0_addr), .r0_data_o(o[0]),
        .r1_v_i(r1_v), .r1_addr_i(r1_addr), .r1_data_o(o[1]));

    bsg_mem_2r1w_sync_core #(.width_p(32), .els_p(32), .read_write_same_addr_p(0)) u_rbw (
        .clk_i(clk), .reset_n_i(rst_n),
        .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
        .r0_v_i(r0_v), .r0_addr_i(r0_addr), .r0_data_o(o[2]),
        .r1_v_i(r1_v), .r1_addr_i(r1_addr), .r1_data_o(o[3]));

    bsg_mem_2r1w_sync_core #(.width_p(32), .els_p(20), .read_write_same_addr_p(0)) u_e20 (
        .clk_i(clk), .reset_n_i(rst_n),
        .w_v_i(w_v20), .w_addr_i(w_addr), .w_data_i(w_data),
        .r0_v_i(r0_v), .r0_addr_i(r0_addr), .r0_data_o(o[4]),
        .r1_v_i(r1_v), .r1_addr_i(r1_addr), .r1_data_o(o[5]));

    typedef struct {
        int          idx;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t         sb_q [$];
    logic [31:0] mem_m [3][32];
    logic [31:0] exp_o [6];
    string       names [6] = '{"wt.r0", "wt.r1", "rbw.r0", "rbw.r1", "e20.r0", "e20.r1"};
    string       phase;
    bit          allow_oor;
    int          n_chk;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input int k, input logic [4:0] a, input bit wv);
        int els;
        els = (k == 2) ? 20 : 32;
        if (int'(a) >= els)
            return 32'h0;
        if (k == 0 && wv && w_addr == a)
            return w_data;
        return mem_m[k][a];
    endfunction

    // One clock: predict, push, run the edge, then pop and compare every output.
    task automatic cycle();
        bit   wv;
        int   els;
        sb_t  e;
        w_v20 = w_v && (allow_oor || w_addr < 5'd20);
        for (int k = 0; k < 3; k++) begin
            wv = (k == 2) ? w_v20 : w_v;
            if (r0_v) exp_o[2*k]   = rd_model(k, r0_addr, wv);
            if (r1_v) exp_o[2*k+1] = rd_model(k, r1_addr, wv);
        end
        for (int k = 0; k < 3; k++) begin
            wv  = (k == 2) ? w_v20 : w_v;
            els = (k == 2) ? 20 : 32;
            if (wv && int'(w_addr) < els)
                mem_m[k][w_addr] = w_data;
        end
        for (int i = 0; i < 6; i++)
            sb_q.push_back('{idx: i, exp: exp_o[i], tag: {phase, ":", names[i]}});
        @(posedge clk);
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, o[e.idx], e.exp);
        end
    endtask

    task automatic idle();
        w_v = 1'b0; r0_v = 1'b0; r1_v = 1'b0;
    endtask

    task automatic set_w(input logic [4:0] a, input logic [31:0] d);
        w_v = 1'b1; w_addr = a; w_data = d;
    endtask

    task automatic set_r(input bit v0, input logic [4:0] a0, input bit v1, input logic [4:0] a1);
        r0_v = v0; r0_addr = a0; r1_v = v1; r1_addr = a1;
    endtask

    initial begin
        n_chk = 0; n_err = 0; allow_oor = 1'b0;
        rst_n = 1'b0; w_v = 1'b0; w_v20 = 1'b0; w_addr = '0; w_data = '0;
        r0_v = 1'b0; r1_v = 1'b0; r0_addr = '0; r1_addr = '0;
        for (int i = 0; i < 6; i++) exp_o[i] = 32'h0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) chk({"reset:", names[i]}, o[i], 32'h0);
        rst_n = 1'b1;

        phase = "idle";
        cycle();

        phase = "fill";
        for (int a = 0; a < 32; a++) begin
            set_w(5'(a), 32'h1000_0000 + 32'(a) * 32'h0101_0101);
            cycle();
        end
        idle();

        phase = "wr";
        set_w(5'd3, 32'hDEAD_BEEF); cycle();
        set_w(5'd7, 32'h1234_5678); cycle();
        idle();

        phase = "rd";
        set_r(1, 5'd3, 1, 5'd7); cycle();
        chk("rd.r0@3", o[0], 32'hDEAD_BEEF);
        chk("rd.r1@7", o[1], 32'h1234_5678);

        phase = "same";
        set_r(1, 5'd3, 1, 5'd3); cycle();
        chk("same.r1@3", o[3], 32'hDEAD_BEEF);
        set_r(0, 5'd0, 1, 5'd7); cycle();
        chk("hold.r0", o[4], 32'hDEAD_BEEF);
        chk("hold.r1@7", o[5], 32'h1234_5678);

        phase = "coll";
        set_w(5'd5, 32'hA5A5_A5A5); set_r(1, 5'd5, 0, 5'd0); cycle();
        chk("coll.wt", o[0], 32'hA5A5_A5A5);
        chk("coll.rbw", o[2], 32'h1000_0000 + 32'd5 * 32'h0101_0101);
        idle();
        set_r(1, 5'd5, 0, 5'd0); cycle();
        chk("coll.next.rbw", o[2], 32'hA5A5_A5A5);

        phase = "pre_rst";
        set_r(1, 5'd3, 1, 5'd7); cycle();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_o[i] = 32'h0;
            chk({"async_rst:", names[i]}, o[i], 32'h0);
        end
        set_w(5'd3, 32'h0); set_r(1, 5'd3, 1, 5'd3); w_v20 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) chk({"in_rst:", names[i]}, o[i], 32'h0);
        rst_n = 1'b1;
        idle();
        phase = "post_rst";
        set_r(1, 5'd3, 1, 5'd3); cycle();
        chk("post_rst.e20@3", o[4], 32'hDEAD_BEEF);

        phase = "oor";
        idle();
        allow_oor = 1'b1;
        set_w(5'd25, 32'hCAFE_F00D); cycle();
        allow_oor = 1'b0;
        idle();
        set_r(1, 5'd25, 1, 5'd5); cycle();
        chk("oor.e20.r0", o[4], 32'h0);
        chk("oor.e20.r1@5", o[5], 32'hA5A5_A5A5);

        phase = "rand";
        for (int n = 0; n < 10000; n++) begin
            w_v = 1'($urandom_range(0, 1));
            w_addr = 5'($urandom_range(0, 31));
            w_data = $urandom;
            r0_v = 1'($urandom_range(0, 1));
            r0_addr = 5'($urandom_range(0, 31));
            r1_v = 1'($urandom_range(0, 1));
            r1_addr = 5'($urandom_range(0, 31));
            if (w_v && r0_v && r0_addr == w_addr) r0_addr = w_addr ^ 5'd1;
            if (w_v && r1_v && r1_addr == w_addr) r1_addr = w_addr ^ 5'd1;
            cycle();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
